// File: rtl/ac_motor_svm_core.sv
// SVM timing core: integrates a stator frequency command into a rotating sector/angle
// and converts angle plus voltage amplitude into the four dwell times per PWM period.
module ac_motor_svm_core #(
    parameter int unsigned CLK_HZ = 100000000,
    parameter int unsigned PWM_HZ = 5000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] frequency,
    input  logic [11:0] u_str,
    output logic [2:0]  sector,
    output logic [11:0] sine_pos,
    output logic [11:0] sine_neg,
    output logic [14:0] t0,
    output logic [14:0] t1,
    output logic [14:0] t2,
    output logic [14:0] t7
);

    localparam int unsigned TS      = CLK_HZ / PWM_HZ;
    localparam int unsigned TS_HALF = TS / 2;
    // Phase step per PWM period for 1 LSB = 0.1 Hz: round(6144 * 2^16 / (10 * PWM_HZ))
    localparam int unsigned PH_INC  = (6144 * 65536 + 5 * PWM_HZ) / (10 * PWM_HZ);
    localparam logic [28:0] PH_WRAP = 29'd402653184;
    localparam real         PI      = 3.14159265358979323846;

    logic [11:0] rom [0:1024];

    // Small epsilon keeps the exact half (k = 512, 2047.5) rounding up despite double error
    for (genvar k = 0; k <= 1024; k++) begin : g_rom
        localparam int ROM_VAL = $rtoi(4095.0 * $sin(PI * k / 3072.0) + 0.5 + 1.0e-6);
        assign rom[k] = 12'(ROM_VAL);
    end

    logic [14:0] cnt_q, cnt_d;
    logic [28:0] phase_q, phase_d, phase_sum;
    logic [24:0] ph_step;
    logic [9:0]  angle;
    logic [10:0] idx_pos, idx_neg;
    logic [2:0]  sector_q;
    logic [11:0] sine_pos_q, sine_neg_q;
    logic [38:0] prod1, prod2;
    logic [14:0] t1m_q, t2m_q, t1m_d, t2m_d;
    logic [14:0] t_rem, t0_d, t7_d;
    logic [14:0] t0_q, t1_q, t2_q, t7_q;

    always_comb begin
        cnt_d     = (cnt_q == 15'(TS - 1)) ? '0 : cnt_q + 15'd1;
        ph_step   = 25'(frequency) * 25'(PH_INC);
        phase_sum = phase_q + 29'(ph_step);
        phase_d   = phase_q;
        if (cnt_q == 15'(TS - 1)) begin
            phase_d = (phase_sum >= PH_WRAP) ? phase_sum - PH_WRAP : phase_sum;
        end
    end

    always_comb begin
        angle   = phase_q[25:16];
        idx_pos = {1'b0, angle};
        idx_neg = 11'd1024 - idx_pos;
    end

    always_comb begin
        prod1 = 39'(u_str) * 39'(sine_neg_q) * 39'(TS);
        prod2 = 39'(u_str) * 39'(sine_pos_q) * 39'(TS);
        t1m_d = 15'(prod1 >> 24);
        t2m_d = 15'(prod2 >> 24);
    end

    // t0/t7 split the remainder from the same t1m/t2m that feed t1/t2, so the sum is exact
    always_comb begin
        t_rem = 15'(TS) - t1m_q - t2m_q;
        t0_d  = t_rem >> 1;
        t7_d  = t_rem - t0_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            phase_q    <= '0;
            sector_q   <= '0;
            sine_pos_q <= '0;
            sine_neg_q <= '0;
            t1m_q      <= '0;
            t2m_q      <= '0;
            t0_q       <= 15'(TS_HALF);
            t1_q       <= '0;
            t2_q       <= '0;
            t7_q       <= 15'(TS - TS_HALF);
        end else begin
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            sector_q   <= phase_q[28:26];
            sine_pos_q <= rom[idx_pos];
            sine_neg_q <= rom[idx_neg];
            t1m_q      <= t1m_d;
            t2m_q      <= t2m_d;
            t0_q       <= t0_d;
            t1_q       <= t1m_q;
            t2_q       <= t2m_q;
            t7_q       <= t7_d;
        end
    end

    assign sector   = sector_q;
    assign sine_pos = sine_pos_q;
    assign sine_neg = sine_neg_q;
    assign t0       = t0_q;
    assign t1       = t1_q;
    assign t2       = t2_q;
    assign t7       = t7_q;

endmodule

// File: tb/tb_ac_motor_svm_core.sv
// Directed bench: a 20000-clock instance for exact dwell values and a 200-clock
// instance (same phase step per period) for multi-period sector walks and wraps.
module tb_ac_motor_svm_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [11:0] freq;
        logic [11:0] u;
        int unsigned ncyc;
        logic [2:0]  sec;
        logic [11:0] sp;
        logic [11:0] sn;
        logic [14:0] e0;
        logic [14:0] e1;
        logic [14:0] e2;
        logic [14:0] e7;
        string       name;
    } vec_t;

    logic        rst_m = 1'b1, rst_s = 1'b1;
    logic [11:0] freq_m = '0, u_m = '0, freq_s = '0, u_s = '0;
    logic [2:0]  sec_m, sec_s;
    logic [11:0] sp_m, sn_m, sp_s, sn_s;
    logic [14:0] t0_m, t1_m, t2_m, t7_m, t0_s, t1_s, t2_s, t7_s;

    int n_vec = 0;
    int n_err = 0;
    int sum_err_m = 0;
    int sum_err_s = 0;
    bit mon_m = 1'b0;
    bit mon_s = 1'b0;

    ac_motor_svm_core #(.CLK_HZ(100000000), .PWM_HZ(5000)) u_dut (
        .clk(clk), .reset(rst_m), .frequency(freq_m), .u_str(u_m),
        .sector(sec_m), .sine_pos(sp_m), .sine_neg(sn_m),
        .t0(t0_m), .t1(t1_m), .t2(t2_m), .t7(t7_m)
    );

    ac_motor_svm_core #(.CLK_HZ(1000000), .PWM_HZ(5000)) u_fast (
        .clk(clk), .reset(rst_s), .frequency(freq_s), .u_str(u_s),
        .sector(sec_s), .sine_pos(sp_s), .sine_neg(sn_s),
        .t0(t0_s), .t1(t1_s), .t2(t2_s), .t7(t7_s)
    );

    function automatic bit times_ok(input logic [14:0] a0, a1, a2, a7, input int ts);
        int s;
        s = int'(a0) + int'(a1) + int'(a2) + int'(a7);
        return (s == ts) && ((int'(a7) == int'(a0)) || (int'(a7) == int'(a0) + 1));
    endfunction

    function automatic logic [2:0] sector_model(input longint p, input longint inc);
        return 3'(((p * inc) % 64'd402653184) >> 26);
    endfunction

    always @(negedge clk) begin
        if (mon_m && !times_ok(t0_m, t1_m, t2_m, t7_m, 20000)) sum_err_m++;
        if (mon_s && !times_ok(t0_s, t1_s, t2_s, t7_s, 200)) sum_err_s++;
    end

    vec_t vecs [0:13];

    initial begin
        vecs[0]  = '{1'b1, 12'd0,    12'd4095, 1,     3'd0, 12'd0,    12'd0,    15'd10000, 15'd0,     15'd0,    15'd10000, "reset"};
        vecs[1]  = '{1'b0, 12'd0,    12'd4095, 1,     3'd0, 12'd0,    12'd3546, 15'd10000, 15'd0,     15'd0,    15'd10000, "rom_stage"};
        vecs[2]  = '{1'b0, 12'd0,    12'd4095, 1,     3'd0, 12'd0,    12'd3546, 15'd10000, 15'd0,     15'd0,    15'd10000, "mul_stage"};
        vecs[3]  = '{1'b0, 12'd0,    12'd4095, 1,     3'd0, 12'd0,    12'd3546, 15'd1345,  15'd17310, 15'd0,    15'd1345,  "full_scale"};
        vecs[4]  = '{1'b0, 12'd0,    12'd4095, 20500, 3'd0, 12'd0,    12'd3546, 15'd1345,  15'd17310, 15'd0,    15'd1345,  "freeze_f0"};
        vecs[5]  = '{1'b0, 12'd0,    12'd0,    1,     3'd0, 12'd0,    12'd3546, 15'd1345,  15'd17310, 15'd0,    15'd1345,  "u_latency_1"};
        vecs[6]  = '{1'b0, 12'd0,    12'd0,    1,     3'd0, 12'd0,    12'd3546, 15'd10000, 15'd0,     15'd0,    15'd10000, "u_zero"};
        vecs[7]  = '{1'b0, 12'd0,    12'd2048, 2,     3'd0, 12'd0,    12'd3546, 15'd5671,  15'd8657,  15'd0,    15'd5672,  "u_half"};
        vecs[8]  = '{1'b1, 12'd2084, 12'd4095, 1,     3'd0, 12'd0,    12'd0,    15'd10000, 15'd0,     15'd0,    15'd10000, "reset_2"};
        vecs[9]  = '{1'b0, 12'd2084, 12'd4095, 30000, 3'd0, 12'd1060, 12'd2896, 15'd344,   15'd14137, 15'd5174, 15'd345,   "angle256"};
        vecs[10] = '{1'b0, 12'd2084, 12'd4095, 15000, 3'd0, 12'd2048, 12'd2048, 15'd3,     15'd9997,  15'd9997, 15'd3,     "angle512"};
        vecs[11] = '{1'b0, 12'd0,    12'd4095, 10,    3'd0, 12'd2048, 12'd2048, 15'd3,     15'd9997,  15'd9997, 15'd3,     "angle512_hold"};
        vecs[12] = '{1'b1, 12'd0,    12'd4095, 1,     3'd0, 12'd0,    12'd0,    15'd10000, 15'd0,     15'd0,    15'd10000, "mid_reset"};
        vecs[13] = '{1'b0, 12'd0,    12'd4095, 3,     3'd0, 12'd0,    12'd3546, 15'd1345,  15'd17310, 15'd0,    15'd1345,  "restart"};

        fork
            begin : main_seq
                for (int i = 0; i < 14; i++) begin
                    @(negedge clk);
                    rst_m  = vecs[i].rst;
                    freq_m = vecs[i].freq;
                    u_m    = vecs[i].u;
                    repeat (vecs[i].ncyc) @(posedge clk);
                    #1;
                    n_vec++;
                    if (sec_m !== vecs[i].sec || sp_m !== vecs[i].sp || sn_m !== vecs[i].sn ||
                        t0_m !== vecs[i].e0 || t1_m !== vecs[i].e1 || t2_m !== vecs[i].e2 ||
                        t7_m !== vecs[i].e7) begin
                        n_err++;
                        $display("FAIL %s: got sec=%0d sp=%0d sn=%0d t0=%0d t1=%0d t2=%0d t7=%0d, want sec=%0d sp=%0d sn=%0d t0=%0d t1=%0d t2=%0d t7=%0d",
                                 vecs[i].name, sec_m, sp_m, sn_m, t0_m, t1_m, t2_m, t7_m,
                                 vecs[i].sec, vecs[i].sp, vecs[i].sn,
                                 vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e7);
                    end
                    mon_m = 1'b1;
                end
            end
            begin : fast_seq
                logic [2:0] prev;
                logic [2:0] exp_sec;
                int         run;
                rst_s  = 1'b1;
                freq_s = 12'd1000;
                u_s    = 12'd4095;
                @(posedge clk);
                #1 mon_s = 1'b1;
                @(negedge clk) rst_s = 1'b0;
                repeat (100) @(posedge clk);
                prev = 3'd0;
                run  = 0;
                for (int p = 0; p < 52; p++) begin
                    #1;
                    exp_sec = sector_model(longint'(p), 64'd8053000);
                    n_vec++;
                    if (sec_s !== exp_sec) begin
                        n_err++;
                        $display("FAIL f1000_sector p=%0d: got %0d, want %0d", p, sec_s, exp_sec);
                    end
                    if (sec_s != prev) begin
                        n_vec++;
                        if (run < 8 || run > 9 || sec_s != ((prev == 3'd5) ? 3'd0 : prev + 3'd1)) begin
                            n_err++;
                            $display("FAIL f1000_run p=%0d: sector %0d->%0d after %0d periods, want +1 after 8..9",
                                     p, prev, sec_s, run);
                        end
                        run  = 0;
                        prev = sec_s;
                    end
                    run++;
                    if (p == 51) begin
                        n_vec++;
                        if (sp_s !== 12'd510) begin
                            n_err++;
                            $display("FAIL f1000_wrap_angle: got sine_pos=%0d, want 510", sp_s);
                        end
                    end
                    repeat (200) @(posedge clk);
                end

                @(negedge clk);
                rst_s  = 1'b1;
                freq_s = 12'd4095;
                @(negedge clk) rst_s = 1'b0;
                repeat (100) @(posedge clk);
                prev = 3'd0;
                for (int p = 0; p < 201; p++) begin
                    #1;
                    exp_sec = sector_model(longint'(p), 64'd32977035);
                    n_vec++;
                    if (sec_s !== exp_sec || sec_s > 3'd5 ||
                        (sec_s != prev && sec_s != ((prev == 3'd5) ? 3'd0 : prev + 3'd1))) begin
                        n_err++;
                        $display("FAIL f4095_sector p=%0d: got %0d (prev %0d), want %0d", p, sec_s, prev, exp_sec);
                    end
                    prev = sec_s;
                    repeat (200) @(posedge clk);
                end
            end
        join

        n_vec++;
        if (sum_err_m != 0) begin
            n_err++;
            $display("FAIL sum_invariant_main: %0d bad cycles, want 0", sum_err_m);
        end
        n_vec++;
        if (sum_err_s != 0) begin
            n_err++;
            $display("FAIL sum_invariant_fast: %0d bad cycles, want 0", sum_err_s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
